// File: rtl/cnn_ctrl_pkg.sv
// cnn_ctrl_pkg: shared state encoding, width helper and default image constants
package cnn_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, NEXT, FIN} state_t;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_IMG_H = 32;
  localparam int NPIX = DEF_IMG_W * DEF_IMG_H;
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/filter_layer_seq_valid_pipe.sv
// valid_pipe: enable-gated valid shift register tracking windows in flight
module valid_pipe #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic tail,
  output logic empty
);
  logic [LAT-1:0] v_q, v_d;
  always_comb v_d = en ? LAT'({v_q, din}) : v_q;
  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else v_q <= v_d;
  end
  assign tail  = v_q[LAT-1];
  assign empty = ~|v_q;
endmodule

// File: rtl/filter_layer_seq.sv
// filter_layer_seq: per-layer weight load, windowed streaming and drain sequencer
module filter_layer_seq
  import cnn_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NLAYER   = 3,
  parameter int NW       = 64,
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int PIPE_LAT = 4,
  parameter int WADDR_W  = 12
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [NLAYER-1:0]         cfg_relu,
  input  logic [NLAYER-1:0]         cfg_clip,
  input  logic [8*NLAYER-1:0]       cfg_relu_c,
  output logic                      busy,
  output logic                      done,
  output logic [clog2(NLAYER)-1:0]  layer,
  output logic                      wmem_rd,
  output logic [WADDR_W-1:0]        wmem_addr,
  input  logic [WIDTH-1:0]          wmem_rdata,
  output logic                      wload_en,
  output logic [clog2(NW)-1:0]      wload_idx,
  output logic [WIDTH-1:0]          wload_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      dp_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [clog2(IMG_H)-1:0]   row,
  output logic [clog2(IMG_W)-1:0]   col,
  output logic                      clip,
  output logic                      relu,
  output logic [7:0]                relu_c
);
  localparam int NP = IMG_W * IMG_H;
  localparam int LW = clog2(NLAYER);
  localparam int IW = clog2(NW);
  localparam int KW = clog2(NW + 1);
  localparam int PW = clog2(NP + 1);
  localparam int RW = clog2(IMG_H);
  localparam int CW = clog2(IMG_W);
  state_t state_q, state_d;
  logic [LW-1:0] layer_q, layer_d, nl, li;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic clip_q, clip_d, relu_q, relu_d, done_q, wload_en_q;
  logic [7:0] relu_c_q, relu_c_d;
  logic [IW-1:0] wload_idx_q;
  logic tail, empty, acc, rd, latch;
  valid_pipe #(.LAT(PIPE_LAT)) u_vp (
    .clk(clk), .rst(resetn), .en(dp_en), .din(acc), .tail(tail), .empty(empty)
  );
  assign dp_en    = ~(tail & ~out_ready);
  assign in_ready = (state_q == RUN) && dp_en && (pix_q < PW'(NP));
  assign acc      = in_valid & in_ready;
  assign rd       = (state_q == LOAD) && (k_q < KW'(NW));
  assign nl       = layer_q + 1'b1;
  assign li       = (state_q == IDLE) ? '0 : nl;
  assign latch    = ((state_q == IDLE) && start) ||
                    ((state_q == NEXT) && (layer_q != LW'(NLAYER - 1)));
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    k_d      = k_q;
    pix_d    = pix_q;
    row_d    = row_q;
    col_d    = col_q;
    clip_d   = latch ? cfg_clip[li] : clip_q;
    relu_d   = latch ? cfg_relu[li] : relu_q;
    relu_c_d = latch ? cfg_relu_c[{li, 3'b000} +: 8] : relu_c_q;
    if (latch) begin
      layer_d = li;
      k_d     = '0;
      pix_d   = '0;
      row_d   = '0;
      col_d   = '0;
    end
    case (state_q)
      IDLE:  state_d = start ? LOAD : IDLE;
      LOAD: begin
        k_d = rd ? k_q + 1'b1 : '0;
        state_d = rd ? LOAD : RUN;
      end
      RUN: if (acc) begin
        pix_d = pix_q + 1'b1;
        col_d = (col_q == CW'(IMG_W - 1)) ? '0 : col_q + 1'b1;
        row_d = (col_q != CW'(IMG_W - 1)) ? row_q :
                (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
        state_d = (pix_q == PW'(NP - 1)) ? DRAIN : RUN;
      end
      DRAIN: state_d = empty ? NEXT : DRAIN;
      NEXT:  state_d = latch ? LOAD : FIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      k_q         <= '0;
      pix_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      clip_q      <= 1'b0;
      relu_q      <= 1'b0;
      relu_c_q    <= '0;
      done_q      <= 1'b0;
      wload_en_q  <= 1'b0;
      wload_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      k_q         <= k_d;
      pix_q       <= pix_d;
      row_q       <= row_d;
      col_q       <= col_d;
      clip_q      <= clip_d;
      relu_q      <= relu_d;
      relu_c_q    <= relu_c_d;
      done_q      <= state_q == FIN;
      wload_en_q  <= rd;
      wload_idx_q <= IW'(k_q);
    end
  end
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign layer      = layer_q;
  assign wmem_rd    = rd;
  assign wmem_addr  = WADDR_W'(layer_q) * WADDR_W'(NW) + WADDR_W'(k_q);
  assign wload_en   = wload_en_q;
  assign wload_idx  = wload_idx_q;
  assign wload_data = wmem_rdata;
  assign out_valid  = tail;
  assign row        = row_q;
  assign col        = col_q;
  assign clip       = clip_q;
  assign relu       = relu_q;
  assign relu_c     = relu_c_q;
endmodule

// File: tb/tb_filter_layer_seq.sv
// tb_filter_layer_seq: directed and randomized checks of the layer sequencer against a transaction model
module tb_filter_layer_seq;
  localparam int NLAYER = 2, NW = 4, IMG_W = 2, IMG_H = 2, PIPE_LAT = 3, NP = IMG_W * IMG_H;
  logic clk, resetn, start, in_valid, out_ready;
  logic [1:0] cfg_relu, cfg_clip;
  logic [15:0] cfg_relu_c, wmem_rdata, wload_data;
  logic busy, done, wmem_rd, wload_en, in_ready, dp_en, out_valid, clip, relu;
  logic [0:0] layer, row, col;
  logic [11:0] wmem_addr;
  logic [1:0] wload_idx;
  logic [7:0] relu_c;
  int checks = 0, errors = 0;
  int rd_n, acc_n, acc_total, out_n, done_n;
  logic prev_rd, hold_prev;
  logic [11:0] prev_addr;
  logic [1:0] s_relu, s_clip;
  logic [15:0] s_c;
  int q[$];

  filter_layer_seq #(.WIDTH(16), .NLAYER(NLAYER), .NW(NW), .IMG_W(IMG_W), .IMG_H(IMG_H),
                     .PIPE_LAT(PIPE_LAT), .WADDR_W(12)) dut (
    .clk(clk), .resetn(resetn), .start(start), .cfg_relu(cfg_relu), .cfg_clip(cfg_clip),
    .cfg_relu_c(cfg_relu_c), .busy(busy), .done(done), .layer(layer), .wmem_rd(wmem_rd),
    .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata), .wload_en(wload_en), .wload_idx(wload_idx),
    .wload_data(wload_data), .in_valid(in_valid), .in_ready(in_ready), .dp_en(dp_en),
    .out_valid(out_valid), .out_ready(out_ready), .row(row), .col(col), .clip(clip),
    .relu(relu), .relu_c(relu_c)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [11:0] a);
    return 16'h5A00 ^ ({4'h0, a} * 16'd37);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) if (wmem_rd) wmem_rdata <= f(wmem_addr);

  // Transaction-level model: reads numbered across the run, accepts counted per layer
  always @(negedge clk) begin
    if (resetn) begin
      prev_rd = 0;
      hold_prev = 0;
    end else begin
      int ml;
      chk("wload_en", wload_en, prev_rd);
      if (wload_en) begin
        chk("wload_idx", wload_idx, prev_addr % NW);
        chk("wload_data", wload_data, f(prev_addr));
      end
      if (wmem_rd) begin
        chk("rd_addr", wmem_addr, rd_n);
        if (rd_n % NW == 0) acc_n = 0;
        rd_n++;
      end
      prev_rd = wmem_rd;
      prev_addr = wmem_addr;
      chk("dp_en", dp_en, !(out_valid && !out_ready));
      if (hold_prev) chk("held", out_valid, 1);
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      hold_prev = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        ml = (rd_n - 1) / NW;
        chk("overrun", acc_n < NP, 1);
        chk("layer", layer, ml);
        chk("row", row, acc_n / IMG_W);
        chk("col", col, acc_n % IMG_W);
        chk("relu", relu, s_relu[ml]);
        chk("clip", clip, s_clip[ml]);
        chk("relu_c", relu_c, s_c[8*ml +: 8]);
        q.push_back(ml);
        acc_n++;
        acc_total++;
      end
      if (out_valid && out_ready) begin
        chk("out_extra", q.size() != 0, 1);
        if (q.size() != 0) void'(q.pop_front());
        out_n++;
      end
      if (done) begin
        chk("done_busy", busy, 0);
        done_n++;
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1;
    start = 1;
    s_relu = cfg_relu; s_clip = cfg_clip; s_c = cfg_relu_c;
    rd_n = 0; acc_n = 0; acc_total = 0; out_n = 0; q.delete();
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic run(input int mode, input int budget);
    int base, n, hc;
    bit held, chg;
    base = done_n; n = 0; hc = 0; held = 0; chg = 0;
    while (done_n == base && n < budget) begin
      @(posedge clk); #1;
      n++;
      case (mode)
        1: in_valid = ~in_valid;
        2: begin
          in_valid = 1'($urandom_range(0, 1));
          out_ready = $urandom_range(0, 3) != 0;
          start = 0;
          if (layer == 1 && !chg) begin
            chg = 1; start = 1;
            cfg_relu = ~cfg_relu; cfg_clip = ~cfg_clip; cfg_relu_c = 16'($urandom);
          end
        end
        3: if (hc > 0) begin out_ready = 0; hc--; end
           else if (!held && out_valid) begin held = 1; out_ready = 0; hc = 4; end
           else out_ready = 1;
        default: ;
      endcase
    end
    start = 0;
    out_ready = 1;
    chk("done_timeout", done_n != base, 1);
    repeat (4) @(negedge clk);
    chk("done_once", done_n - base, 1);
    chk("outputs", out_n, NLAYER * NP);
    chk("accepts", acc_total, NLAYER * NP);
    chk("queue_empty", q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int n, base;
    resetn = 1; start = 0; in_valid = 0; out_ready = 1;
    cfg_relu = 2'b10; cfg_clip = 2'b01; cfg_relu_c = 16'h0A05;
    rd_n = 0; acc_n = 0; acc_total = 0; out_n = 0; done_n = 0;
    repeat (3) @(posedge clk); #1;
    resetn = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rd", wmem_rd, 0);
    chk("rst_wload", wload_en, 0); chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_clip", clip, 0); chk("rst_relu", relu, 0); chk("rst_relu_c", relu_c, 0); chk("rst_dp_en", dp_en, 1);

    in_valid = 1;
    do_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    chk("run_entry_cycle", n, 6);
    chk("l0_relu", relu, 0); chk("l0_relu_c", relu_c, 8'h05); chk("l0_busy", busy, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    chk("first_out_latency", n, PIPE_LAT);
    run(0, 200);

    do_start();
    run(3, 300);

    in_valid = 0;
    do_start();
    run(1, 300);

    for (int r = 0; r < 3; r++) begin
      cfg_relu = 2'($urandom); cfg_clip = 2'($urandom); cfg_relu_c = 16'($urandom);
      do_start();
      run(2, 1000);
    end

    in_valid = 1; out_ready = 1;
    do_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!(layer == 1 && in_ready) && n < 100);
    chk("reach_layer1", layer == 1 && in_ready, 1);
    base = done_n;
    @(posedge clk); #1 resetn = 1;
    @(posedge clk); #1 resetn = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0); chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0); chk("abort_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_n, base);
    do_start();
    run(0, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/filter_layer_seq.md
Name: filter_layer_seq

Overview:
- Sequences the multi-layer filter datapath through a full image, one layer at a time.
- Per layer: loads that layer's weights and bias from an external weight memory, drives `clip`/`relu`/`relu_c`, then streams `IMG_W*IMG_H` input windows through a pipeline of fixed latency with valid/ready backpressure.
- Drains the pipeline, then advances to the next layer.
- Sits between the top-level CPU/config interface and the filter datapath instance.

Parameters:
- `WIDTH`, 16: datapath word width (weights, bias).
- `NLAYER`, 3: number of layers to sequence.
- `NW`, 64: weight+bias words per layer; index `NW-1` is the bias slot.
- `IMG_W`, 32: windows per row.
- `IMG_H`, 32: rows per image.
- `PIPE_LAT`, 4: datapath latency in cycles, input window to result; must be ≥ 1.
- `WADDR_W`, 12: weight memory address width; must satisfy `NLAYER*NW ≤ 2**WADDR_W`.

Ports:
- `clk`, in, 1: clock.
- `resetn`, in, 1: synchronous reset, **active-high**.
- `start`, in, 1: begin a full run; ignored unless IDLE.
- `cfg_relu`, in, `NLAYER`: per-layer ReLU enable.
- `cfg_clip`, in, `NLAYER`: per-layer clip enable.
- `cfg_relu_c`, in, `8*NLAYER`: per-layer ReLU constant; layer L uses bits `[8L+7:8L]`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at run end.
- `layer`, out, `clog2(NLAYER)`: current layer index.
- `wmem_rd`, out, 1: weight memory read strobe.
- `wmem_addr`, out, `WADDR_W`: weight memory address.
- `wmem_rdata`, in, `WIDTH`: read data, returned one cycle after `wmem_rd`.
- `wload_en`, out, 1: write strobe into datapath weight registers.
- `wload_idx`, out, `clog2(NW)`: weight register index.
- `wload_data`, out, `WIDTH`: weight value; equals `wmem_rdata`, registered.
- `in_valid`, in, 1: input window valid.
- `in_ready`, out, 1: sequencer accepts the window.
- `dp_en`, out, 1: datapath pipeline advance enable.
- `out_valid`, out, 1: datapath result valid.
- `out_ready`, in, 1: downstream accepts the result.
- `row`, out, `clog2(IMG_H)`: position of the window being accepted.
- `col`, out, `clog2(IMG_W)`: position of the window being accepted.
- `clip`, out, 1: datapath clip control, registered from `cfg` for the current layer.
- `relu`, out, 1: datapath ReLU control, registered from `cfg` for the current layer.
- `relu_c`, out, 8: datapath ReLU constant, registered from `cfg` for the current layer.

Behaviour:
- Reset (`resetn`=1 at a clock edge):
  - state=IDLE; all counters 0.
  - `busy`, `done`, `wmem_rd`, `wload_en`, `in_ready`, `out_valid`, `clip`, `relu` = 0; `relu_c` = 0; `dp_en` = 1.
  - Valid shift register cleared.
  - Reset mid-run aborts immediately; no `done` pulse.
- FSM states: IDLE, LOAD, RUN, DRAIN, NEXT, FIN.
- IDLE:
  - `start`=1 → LOAD, `layer`=0.
  - `clip`/`relu`/`relu_c` latched for layer 0 on the same edge.
- LOAD:
  - Issues `NW` consecutive reads: `wmem_addr = layer*NW + k`, k = 0..NW-1, `wmem_rd`=1 for exactly `NW` cycles.
  - `wload_en` follows one cycle later, `wload_idx`=k.
  - After the last `wload_en` → RUN.
  - LOAD takes `NW+1` cycles.
- RUN:
  - Valid shift register `v[PIPE_LAT-1:0]`.
  - `stall = v[PIPE_LAT-1] & ~out_ready`; `dp_en = ~stall`.
  - `in_ready = (state==RUN) & dp_en & (pix_cnt < IMG_W*IMG_H)`.
  - When `dp_en`: `v` shifts, `v[0] = in_valid & in_ready`.
  - `out_valid = v[PIPE_LAT-1]`.
  - Accept increments `col`; on wrap from `IMG_W-1` to 0, `row` increments; `pix_cnt` increments.
  - `row`/`col` reflect the window accepted in the current cycle.
  - After the last accept → DRAIN.
- DRAIN:
  - `in_ready`=0; the pipeline continues advancing under `dp_en`.
  - When `v`==0 → NEXT.
- NEXT:
  - `layer`==`NLAYER-1` → FIN.
  - Else `layer`++, clear `row`/`col`/`pix_cnt`, latch next-layer `cfg` → LOAD.
- FIN: `done`=1 for one cycle → IDLE; `busy` drops in that same cycle.
- Simultaneous output and input: when `out_ready` and `v[PIPE_LAT-1]` are both 1, a new window is accepted in the same cycle (full throughput).
- Downstream hold: `out_valid` held high while `out_ready`=0; datapath frozen via `dp_en`=0.
- Mid-run config changes: `start` and `cfg_*` changes during a run are ignored until the next layer latch or the next IDLE.
- `in_valid`=0 in RUN inserts a bubble: `v[0]`=0, counters hold.

Decomposition:
- Shared package `cnn_ctrl_pkg`:
  - FSM state enum.
  - Function `clog2`.
  - Constant `NPIX = IMG_W*IMG_H`.
- Natural sub-module: `valid_pipe`, a `PIPE_LAT`-deep valid shift register with enable, exposing `empty` and `tail`.

Test Plan:
- Config `NLAYER`=2, `NW`=4, `IMG_W`=`IMG_H`=2, `PIPE_LAT`=3; `start` pulse → `wmem_addr` 0,1,2,3; `wload_idx` 0..3 one cycle later; RUN entered at cycle 6 after `start`.
- `in_valid`=1 and `out_ready`=1 constantly → 4 `out_valid` pulses per layer, first 3 cycles after the first accept.
- Layer 1 reads `wmem_addr` 4..7; `done` pulses once; total 8 outputs.
- `out_ready`=0 for 5 cycles while `out_valid`=1 → `dp_en`=0, `in_ready`=0, `out_valid` held; no output lost or duplicated; output count still 4 per layer.
- `in_valid` toggles 1,0,1,0 → `row`/`col` sequence (0,0),(0,1),(1,0),(1,1) only on accepts; DRAIN entered only after the 4th accept.
- `cfg_relu`=2'b10, `cfg_relu_c`=16'h0A05 → layer 0: `relu`=0, `relu_c`=5; layer 1: `relu`=1, `relu_c`=10.
- Reset asserted in RUN of layer 1 → next cycle IDLE, `busy`=0, `out_valid`=0, no `done`; a new `start` restarts at `wmem_addr`=0.
